moore_fig_5_19_driver: RTL and testbench

- Initiator side of the Fig. 5-19 Moore FSM: produces the serial x stream that steers that FSM to a requested state.
- Holds a shadow copy of the FSM state and emits one routing bit per clock along the shortest path.
- Checks the FSM's y output against the shadow state each cycle.
- Sits between a test/sequence controller (request handshake) and the FSM's x_in/y_out pins. Both blocks share one clock.

---
 rtl/moore_fig_5_19_driver.sv | 98 +++++++++
 tb/tb_moore_fig_5_19_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/moore_fig_5_19_driver.sv
// Initiator for the Fig. 5-19 Moore FSM: keeps a shadow of the FSM state and
// emits one x bit per clock along the shortest path to a requested state.
module moore_fig_5_19_driver #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_target,
    output logic       req_ready,
    output logic       x_out,
    output logic       done,
    output logic [1:0] steps,
    input  logic [1:0] y_in,
    output logic       err
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STEER = 1'b1
    } ctrl_t;

    state_t     shadow_q, shadow_d;
    state_t     target_q, target_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [1:0] steps_q, steps_d;
    logic       err_q, err_d;

    function automatic state_t fsm_next(input state_t s, input logic x);
        state_t n;
        case (s)
            S0:      n = x ? S0 : S1;
            S1:      n = x ? S2 : S3;
            S2:      n = x ? S2 : S3;
            default: n = x ? S3 : S0;
        endcase
        return n;
    endfunction

    // Hold bit is 1 in every state; in S1 that bit exits to S2, so S1 is transient.
    // The only route bit of 1 is S1->S2; every other unequal pair steps with 0.
    always_comb begin
        ctrl_d    = ctrl_q;
        target_d  = target_q;
        steps_d   = steps_q;
        req_ready = 1'b0;
        done      = 1'b0;
        x_out     = 1'b1;
        case (ctrl_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    target_d = state_t'(req_target);
                    steps_d  = '0;
                    ctrl_d   = STEER;
                end
            end
            default: begin
                if (shadow_q == target_q) begin
                    done   = 1'b1;
                    ctrl_d = IDLE;
                end else begin
                    x_out   = (shadow_q == S1) && (target_q == S2);
                    steps_d = steps_q + 2'd1;
                end
            end
        endcase
        shadow_d = fsm_next(shadow_q, x_out);
        err_d    = CHECK_EN ? (err_q | (y_in != shadow_q)) : 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q <= S0;
            target_q <= S0;
            ctrl_q   <= IDLE;
            steps_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            target_q <= target_d;
            ctrl_q   <= ctrl_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
        end
    end

    assign steps = steps_q;
    assign err   = err_q;

endmodule

// File: tb/tb_moore_fig_5_19_driver.sv
// Bench for moore_fig_5_19_driver: a behavioural Fig. 5-19 FSM closes the loop,
// a vector table drives one cycle per row, and hand sequences cover resets.
module tb_moore_fig_5_19_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_target = 2'd0;
    logic       req_ready, x_out, done, err;
    logic [1:0] steps;
    logic       req_ready2, x_out2, done2, err2;
    logic [1:0] steps2;

    logic [1:0] fsm_y;
    logic       force_en = 1'b0;
    logic [1:0] force_val = 2'd0;
    logic [1:0] y_in;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    moore_fig_5_19_driver #(.CHECK_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_target(req_target),
        .req_ready(req_ready), .x_out(x_out), .done(done), .steps(steps),
        .y_in(y_in), .err(err)
    );

    moore_fig_5_19_driver #(.CHECK_EN(1'b0)) dut_nochk (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_target(req_target),
        .req_ready(req_ready2), .x_out(x_out2), .done(done2), .steps(steps2),
        .y_in(y_in), .err(err2)
    );

    // Fig. 5-19 FSM: S0 -0->S1, S1 -1->S2 / -0->S3, S2 -0->S3, S3 -0->S0, else stay.
    function automatic logic [1:0] fig_next(input logic [1:0] s, input logic x);
        logic [1:0] n;
        case (s)
            2'd0:    n = x ? 2'd0 : 2'd1;
            2'd1:    n = x ? 2'd2 : 2'd3;
            2'd2:    n = x ? 2'd2 : 2'd3;
            default: n = x ? 2'd3 : 2'd0;
        endcase
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) fsm_y <= 2'd0;
        else       fsm_y <= fig_next(fsm_y, x_out);
    end

    assign y_in = force_en ? force_val : fsm_y;

    typedef struct {
        logic       v;
        logic [1:0] t;
        logic       fy;
        logic [1:0] yf;
        logic       rdy;
        logic       x;
        logic       dn;
        logic [1:0] st;
        logic [1:0] y;
        logic       e;
    } vec_t;

    function automatic vec_t mk(input int v, input int t, input int fy, input int yf,
                                input int rdy, input int x, input int dn, input int st,
                                input int y, input int e);
        vec_t r;
        r.v = v[0]; r.t = t[1:0]; r.fy = fy[0]; r.yf = yf[1:0];
        r.rdy = rdy[0]; r.x = x[0]; r.dn = dn[0]; r.st = st[1:0];
        r.y = y[1:0]; r.e = e[0];
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    localparam int NV = 30;
    vec_t vecs[NV];

    initial begin
        //                v  t fy yf rdy x dn st y e
        // req S2 from S0: x 1,0,1,1
        vecs[0]  = mk(1, 2, 0, 0, 1, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1, 1, 2, 2, 0);
        // req S1 from S2: three steps, then the idle hold moves to S2
        vecs[4]  = mk(1, 1, 0, 0, 1, 1, 0, 2, 2, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 1, 3, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 1, 0, 3, 2, 0);
        // back to S0 from S2
        vecs[10] = mk(1, 0, 0, 0, 1, 1, 0, 3, 2, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
        // req S0 while in S0: done in first STEER cycle, steps 0
        vecs[14] = mk(1, 0, 0, 0, 1, 1, 0, 2, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // req_valid held: S3 then S0, second accepted after done
        vecs[17] = mk(1, 3, 0, 0, 1, 1, 0, 0, 0, 0);
        vecs[18] = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[19] = mk(1, 3, 0, 0, 0, 0, 0, 1, 1, 0);
        vecs[20] = mk(1, 0, 0, 0, 0, 1, 1, 2, 3, 0);
        vecs[21] = mk(1, 0, 0, 0, 1, 1, 0, 2, 3, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        // corrupt y to 3 for one cycle while shadow is S1: err sticks
        vecs[25] = mk(1, 2, 0, 0, 1, 1, 0, 1, 0, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[27] = mk(0, 0, 1, 3, 0, 1, 0, 1, 3, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 1, 1, 2, 2, 1);
        vecs[29] = mk(0, 0, 0, 0, 1, 1, 0, 2, 2, 1);

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", -1, {1'b0, req_ready}, 2'd1);
        chk("rst_x",     -1, {1'b0, x_out},     2'd1);
        chk("rst_done",  -1, {1'b0, done},      2'd0);
        chk("rst_steps", -1, steps,             2'd0);
        chk("rst_err",   -1, {1'b0, err},       2'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clock);
            #1;
            req_valid  = vecs[i].v;
            req_target = vecs[i].t;
            force_en   = vecs[i].fy;
            force_val  = vecs[i].yf;
            @(negedge clock);
            chk("ready", i, {1'b0, req_ready}, {1'b0, vecs[i].rdy});
            chk("x_out", i, {1'b0, x_out},     {1'b0, vecs[i].x});
            chk("done",  i, {1'b0, done},      {1'b0, vecs[i].dn});
            chk("steps", i, steps,             vecs[i].st);
            chk("y_in",  i, y_in,              vecs[i].y);
            chk("err",   i, {1'b0, err},       {1'b0, vecs[i].e});
            chk("err_nochk", i, {1'b0, err2},  2'd0);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        force_en  = 1'b0;
        @(negedge clock);
        chk("err_sticky", 100, {1'b0, err}, 2'd1);

        // reset one cycle into an S0->S2 request (currently at S2: go via reset)
        reset = 1'b1;
        #2;
        chk("rst2_err", 101, {1'b0, err}, 2'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        req_valid  = 1'b1;
        req_target = 2'd2;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #2;
        chk("pre_rst_steps", 102, steps, 2'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 103, {1'b0, req_ready}, 2'd1);
        chk("mid_rst_x",     104, {1'b0, x_out},     2'd1);
        chk("mid_rst_done",  105, {1'b0, done},      2'd0);
        chk("mid_rst_steps", 106, steps,             2'd0);
        @(negedge clock);
        chk("mid_rst_done2", 107, {1'b0, done},      2'd0);
        reset = 1'b0;

        // after release, req S3 completes in accept + 2 steps + done cycle
        @(posedge clock);
        #1;
        req_valid  = 1'b1;
        req_target = 2'd3;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        begin
            int cyc;
            cyc = 0;
            @(negedge clock);
            while (!done && cyc < 10) begin
                @(negedge clock);
                cyc++;
            end
            chk("s3_done_seen", 108, {1'b0, done}, 2'd1);
            chk("s3_latency",   109, cyc[1:0],     2'd2);
            chk("s3_steps",     110, steps,        2'd2);
            chk("s3_y",         111, y_in,         2'd3);
            chk("s3_err",       112, {1'b0, err},  2'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
